mux_4to1: RTL and testbench

- Registered 4-input, WIDTH-bit data selector.
- A 2-bit select steers one of four operand buses (a, b, c, d) to a single output register.
- Used as a generic datapath steering element wherever a small lane or operand pick is needed.
- One clock domain. Synchronous reset.

---
 rtl/mux_4to1_pkg.sv | 16 +
 rtl/mux_4to1_core.sv | 34 +++
 rtl/mux_4to1.sv | 62 ++++++
 tb/tb_mux_4to1.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_4to1_pkg.sv
// ----------------------------------------------------------------------------
// mux_4to1_pkg
// Shared constants for the registered 4:1 data selector.
//   SEL_A..SEL_D  : select codes that steer operand a, b, c or d
//   DEFAULT_WIDTH : default operand/result width
// ----------------------------------------------------------------------------
package mux_4to1_pkg;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_D = 2'd3;

   localparam int DEFAULT_WIDTH = 4;

endpackage : mux_4to1_pkg

// File: rtl/mux_4to1_core.sv
// ----------------------------------------------------------------------------
// mux_4to1_core
// Purely combinational WIDTH-bit 4:1 selector.
// Ports:
//   a, b, c, d : operand buses (WIDTH bits each)
//   sel        : select code, 00 -> a, 01 -> b, 10 -> c, 11 -> d
//   y          : selected operand (WIDTH bits)
// ----------------------------------------------------------------------------
module mux_4to1_core
   import mux_4to1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   // Full decode of the 2-bit select. The zero default only keeps the block
   // latch-free; every known select value is covered by a case item.
   always_comb begin
      y = '0;
      unique case (sel)
         SEL_A: y = a;
         SEL_B: y = b;
         SEL_C: y = c;
         SEL_D: y = d;
      endcase
   end

endmodule : mux_4to1_core

// File: rtl/mux_4to1.sv
// ----------------------------------------------------------------------------
// mux_4to1
// Registered 4-input WIDTH-bit data selector with a valid qualifier.
// Ports:
//   clk       : system clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   a,b,c,d   : operand buses (WIDTH bits)
//   sel       : select code for the operand to capture
//   in_valid  : qualifies operands and sel for capture this cycle
//   out       : registered selected operand
//   out_valid : one-cycle pulse per captured selection
//   sel_q     : registered sel value that produced out
// ----------------------------------------------------------------------------
module mux_4to1
   import mux_4to1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [1:0]       sel_q
);

   logic [WIDTH-1:0] selected;

   mux_4to1_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .sel (sel),
      .y   (selected)
   );

   // Output stage. Reset wins over in_valid so a selection presented in the
   // reset cycle is dropped. Without in_valid the data and sel registers keep
   // their last captured values while the valid pulse falls back to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         sel_q     <= SEL_A;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out       <= selected;
         sel_q     <= sel;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// ----------------------------------------------------------------------------
// tb_mux_4to1
// Self-checking bench for mux_4to1. Two instances share control signals:
// one at WIDTH = 4 and one at WIDTH = 8. A behavioural reference picks the
// operand by array index and is compared every cycle; directed steps also
// check hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_mux_4to1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] sel;
   logic [3:0] a4, b4, c4, d4;
   logic [7:0] a8, b8, c8, d8;

   logic [3:0] out4;
   logic       out_valid4;
   logic [1:0] sel_q4;
   logic [7:0] out8;
   logic       out_valid8;
   logic [1:0] sel_q8;

   logic [3:0] ref_out4;
   logic [7:0] ref_out8;
   logic [1:0] ref_sel;
   logic       ref_valid;

   logic check_en = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mux_4to1 #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a4),
      .b         (b4),
      .c         (c4),
      .d         (d4),
      .sel       (sel),
      .in_valid  (in_valid),
      .out       (out4),
      .out_valid (out_valid4),
      .sel_q     (sel_q4)
   );

   mux_4to1 #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a8),
      .b         (b8),
      .c         (c8),
      .d         (d8),
      .sel       (sel),
      .in_valid  (in_valid),
      .out       (out8),
      .out_valid (out_valid8),
      .sel_q     (sel_q8)
   );

   // Reference behaviour: operands are viewed as a four-entry table and the
   // select code is simply the table index. The result appears one edge later.
   always @(posedge clk) begin
      logic [3:0] ops4 [4];
      logic [7:0] ops8 [4];
      ops4[0] = a4; ops4[1] = b4; ops4[2] = c4; ops4[3] = d4;
      ops8[0] = a8; ops8[1] = b8; ops8[2] = c8; ops8[3] = d8;
      if (rst_n === 1'b0) begin
         ref_out4  <= 4'd0;
         ref_out8  <= 8'd0;
         ref_sel   <= 2'd0;
         ref_valid <= 1'b0;
      end else begin
         ref_valid <= in_valid;
         if (in_valid) begin
            ref_out4 <= ops4[sel];
            ref_out8 <= ops8[sel];
            ref_sel  <= sel;
         end
      end
   end

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Every-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         checkField("model out4",      64'(out4),       64'(ref_out4));
         checkField("model out8",      64'(out8),       64'(ref_out8));
         checkField("model out_valid", 64'(out_valid4), 64'(ref_valid));
         checkField("model valid8",    64'(out_valid8), 64'(ref_valid));
         checkField("model sel_q",     64'(sel_q4),     64'(ref_sel));
         checkField("model sel_q8",    64'(sel_q8),     64'(ref_sel));
      end
   end

   task automatic applyStimulus(input logic rst, input logic iv, input logic [1:0] s,
                                input logic [3:0] va4, input logic [3:0] vb4,
                                input logic [3:0] vc4, input logic [3:0] vd4,
                                input logic [7:0] va8, input logic [7:0] vb8,
                                input logic [7:0] vc8, input logic [7:0] vd8);
      rst_n    = rst;
      in_valid = iv;
      sel      = s;
      a4 = va4; b4 = vb4; c4 = vc4; d4 = vd4;
      a8 = va8; b8 = vb8; c8 = vc8; d8 = vd8;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] e4, input logic [7:0] e8,
                              input logic [1:0] esel, input logic evalid);
      checkField({name, " out4"},  64'(out4),       64'(e4));
      checkField({name, " out8"},  64'(out8),       64'(e8));
      checkField({name, " sel_q"}, 64'(sel_q4),     64'(esel));
      checkField({name, " valid"}, 64'(out_valid4), 64'(evalid));
   endtask

   initial begin
      // Reset held two cycles while a valid selection of a is offered.
      applyStimulus(1'b0, 1'b1, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h00, 8'h00, 8'h00);
      checkOutput("reset", 4'h0, 8'h00, 2'b00, 1'b0);
      check_en = 1'b1;

      // Sweep every select code with distinct operands, back to back.
      for (int s = 0; s < 4; s++) begin
         applyStimulus(1'b1, 1'b1, 2'(s), 4'h0, 4'h1, 4'h2, 4'h3, 8'hA5, 8'h5A, 8'hFF, 8'h00);
         case (s)
            0: checkOutput("sweep sel0", 4'h0, 8'hA5, 2'b00, 1'b1);
            1: checkOutput("sweep sel1", 4'h1, 8'h5A, 2'b01, 1'b1);
            2: checkOutput("sweep sel2", 4'h2, 8'hFF, 2'b10, 1'b1);
            default: checkOutput("sweep sel3", 4'h3, 8'h00, 2'b11, 1'b1);
         endcase
      end

      // Capture c, then change sel and c with in_valid low: output must hold.
      applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h1, 4'h2, 4'h3, 8'hA5, 8'h5A, 8'hFF, 8'h00);
      checkOutput("hold capture", 4'h2, 8'hFF, 2'b10, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b11, 4'h0, 4'h1, 4'hF, 4'h3, 8'hA5, 8'h5A, 8'h11, 8'h22);
      checkOutput("hold 1", 4'h2, 8'hFF, 2'b10, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'h7, 4'h1, 4'hF, 4'h3, 8'h33, 8'h5A, 8'h11, 8'h22);
      checkOutput("hold 2", 4'h2, 8'hFF, 2'b10, 1'b0);

      // Reset in the same cycle as a valid selection of d.
      applyStimulus(1'b0, 1'b1, 2'b11, 4'h0, 4'h1, 4'h2, 4'h9, 8'hA5, 8'h5A, 8'hFF, 8'h3C);
      checkOutput("midreset", 4'h0, 8'h00, 2'b00, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h6, 4'h2, 4'h9, 8'hA5, 8'hC3, 8'hFF, 8'h3C);
      checkOutput("post reset", 4'h6, 8'hC3, 2'b01, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, 4'h6, 4'h2, 4'h9, 8'hA5, 8'hC3, 8'hFF, 8'h3C);
      checkOutput("pulse end", 4'h6, 8'hC3, 2'b01, 1'b0);

      // Random traffic with occasional resets; the reference checks every cycle.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)),
                       4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mux_4to1
